// File: rtl/serial_comparator.sv
// serial_comparator
//   Compares two WIDTH-bit operands DIGIT bits per clock, most significant
//   chunk first, and reports equality / ordering plus the Hamming distance
//   between the operands. A run always takes exactly STEPS = WIDTH/DIGIT
//   cycles; the result registers hold their value until the next result.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset (clears every register)
//   start       request a compare, sampled only while idle
//   signed_mode 1 = two's-complement compare, 0 = unsigned
//   a, b        operands, captured on the accepting edge
//   busy        high while the chunks are being processed
//   done        one-cycle pulse when eq/gt/lt/hamming carry a new result
//   eq, gt, lt  A == B, A > B, A < B (exactly one set after a compare)
//   hamming     popcount(A ^ B)
module serial_comparator #(
    parameter  int WIDTH = 8,
    parameter  int DIGIT = 2,
    localparam int STEPS = WIDTH / DIGIT,
    localparam int HW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic [HW-1:0] hamming
);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh;   // operands, shifted left one chunk per step
    logic             mode_r;
    logic [CW-1:0]    step;
    logic [HW-1:0]    ham_acc;
    logic             dec_set;      // a differing chunk has been seen
    logic             dec_gt;       // ordering decided by that first chunk

    logic [DIGIT-1:0] flip, chunk_a, chunk_b;
    logic [HW-1:0]    ham_sum;
    logic             set_sum, gt_sum, last_step;

    function automatic logic [HW-1:0] popcount(input logic [DIGIT-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c = c + HW'(v[i]);
        end
        return c;
    endfunction

    assign last_step = (step == CW'(STEPS - 1));

    // Signed compare is an unsigned compare with both sign bits inverted; the
    // sign bit only lives in the first (MSB) chunk. Inverting both sign bits
    // leaves A ^ B unchanged, so the Hamming count is mode-independent.
    always_comb begin
        flip            = '0;
        flip[DIGIT-1]   = mode_r && (step == '0);
        chunk_a         = a_sh[WIDTH-1 -: DIGIT] ^ flip;
        chunk_b         = b_sh[WIDTH-1 -: DIGIT] ^ flip;
        ham_sum         = ham_acc + popcount(chunk_a ^ chunk_b);
        set_sum         = dec_set || (chunk_a != chunk_b);
        gt_sum          = dec_set ? dec_gt : (chunk_a > chunk_b);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            hamming <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            mode_r  <= 1'b0;
            step    <= '0;
            ham_acc <= '0;
            dec_set <= 1'b0;
            dec_gt  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        mode_r  <= signed_mode;
                        step    <= '0;
                        ham_acc <= '0;
                        dec_set <= 1'b0;
                        dec_gt  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh << DIGIT;
                    b_sh    <= b_sh << DIGIT;
                    step    <= step + 1'b1;
                    ham_acc <= ham_sum;
                    dec_set <= set_sum;
                    dec_gt  <= gt_sum;
                    if (last_step) begin
                        eq      <= !set_sum;
                        gt      <= set_sum && gt_sum;
                        lt      <= set_sum && !gt_sum;
                        hamming <= ham_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
module tb_serial_comparator;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int STEPS = WIDTH / DIGIT;
    localparam int HW    = $clog2(WIDTH + 1);
    localparam int NVEC  = 26;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, eq, gt, lt;
    logic [HW-1:0]    hamming;

    serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt),
        .hamming(hamming)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct packed {
        logic          eq;
        logic          gt;
        logic          lt;
        logic [HW-1:0] ham;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sm;
        res_t             exp;
    } vec_t;

    res_t sb[$];
    res_t prev = '0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    vec_t tbl[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic res_t mk(input logic e, input logic g, input logic l, input int h);
        res_t r;
        r.eq = e; r.gt = g; r.lt = l; r.ham = HW'(h);
        return r;
    endfunction

    // Reference: native signed/unsigned comparison and $countones.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sm);
        logic g;
        g = sm ? ($signed(x) > $signed(y)) : (x > y);
        return mk(x == y, g, !g && (x != y), $countones(x ^ y));
    endfunction

    function automatic logic [31:0] r32(input res_t r);
        return {{(29-HW){1'b0}}, r};
    endfunction

    function automatic res_t cur();
        res_t r;
        r.eq = eq; r.gt = gt; r.lt = lt; r.ham = hamming;
        return r;
    endfunction

    function automatic logic [31:0] all_out();
        return {{(27-HW){1'b0}}, busy, done, eq, gt, lt, hamming};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", r32(cur()), r32(e));
                prev = e;
            end
        end
    end

    // Called at E0+#1; counts edges until done and busy samples before it.
    task automatic wait_done(input string nm);
        int k;
        int bcnt;
        k = 0;
        bcnt = int'(busy);
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) break;
            bcnt += int'(busy);
        end
        chk({nm, "_latency"}, k, STEPS);
        chk({nm, "_busy_cycles"}, bcnt, STEPS);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xsm, input res_t exp, input string nm);
        @(negedge clk);
        a = xa; b = xb; signed_mode = xsm; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_held_while_busy"}, r32(cur()), r32(prev));
        // Scramble inputs: the operation in flight must not see them.
        a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
        wait_done(nm);
        @(posedge clk); #1;
        chk({nm, "_back_to_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int   d0;
        logic [31:0] acc;
        logic [WIDTH-1:0] x, y;
        logic s;

        tbl[0] = '{8'h5A, 8'h5A, 1'b0, mk(1, 0, 0, 0)};
        tbl[1] = '{8'h80, 8'h7F, 1'b0, mk(0, 1, 0, 8)};
        tbl[2] = '{8'h80, 8'h7F, 1'b1, mk(0, 0, 1, 8)};
        tbl[3] = '{8'h00, 8'hFF, 1'b0, mk(0, 0, 1, 8)};
        tbl[4] = '{8'h00, 8'hFF, 1'b1, mk(0, 1, 0, 8)};
        tbl[5] = '{8'h7F, 8'h80, 1'b1, mk(0, 1, 0, 8)};
        tbl[6] = '{8'hFF, 8'hFE, 1'b1, mk(0, 1, 0, 1)};
        tbl[7] = '{8'h12, 8'h13, 1'b0, mk(0, 0, 1, 1)};
        tbl[8] = '{8'hC3, 8'hC3, 1'b1, mk(1, 0, 0, 0)};
        tbl[9] = '{8'h01, 8'h00, 1'b0, mk(0, 1, 0, 1)};
        for (int i = 10; i < NVEC; i++) begin
            x = WIDTH'($urandom);
            y = (i % 2 == 1) ? (x ^ WIDTH'(1 << $urandom_range(0, WIDTH-1))) : WIDTH'($urandom);
            s = 1'($urandom);
            tbl[i] = '{x, y, s, model(x, y, s)};
        end

        // Asynchronous reset with the clock stopped.
        #1 rst = 1'b1;
        #2;
        chk("reset_async_outputs", all_out(), 32'd0);

        clk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            acc |= all_out();
        end
        chk("idle_quiet", acc, 32'd0);
        prev = '0;

        for (int i = 0; i < NVEC; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // start held high; a changes after acceptance; restart after DONE.
        d0 = done_cnt;
        @(negedge clk);
        a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
        sb.push_back(mk(0, 0, 1, 1));
        @(posedge clk); #1;
        a = 8'hFF;
        wait_done("held_start");
        sb.push_back(mk(0, 1, 0, 5));
        @(posedge clk); #1;
        chk("held_start_ignored_in_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        chk("held_start_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("held_start_second");
        @(posedge clk); #1;
        chk("held_start_done_count", done_cnt - d0, 32'd2);

        // Reset mid-run aborts without a done pulse or leftover results.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("reset_mid_run_outputs", all_out(), 32'd0);
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mid_run_no_done", done_cnt - d0, 32'd0);
        prev = '0;
        do_op(8'h01, 8'h00, 1'b0, mk(0, 1, 0, 1), "after_reset");

        // start in DONE ignored, accepted in the following IDLE cycle.
        @(negedge clk);
        a = 8'h80; b = 8'h7F; signed_mode = 1'b0; start = 1'b1;
        sb.push_back(mk(0, 1, 0, 8));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("done_start_first");
        start = 1'b1; a = 8'h01; b = 8'h02;
        sb.push_back(mk(0, 0, 1, 2));
        @(posedge clk); #1;
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("done_start_accepted", {31'd0, busy}, 32'd1);
        start = 1'b0;
        chk("done_start_prior_held", r32(cur()), r32(mk(0, 1, 0, 8)));
        wait_done("done_start_second");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: operand width in bits, at least 2.
REQ-002 The module SHALL have parameter DIGIT, default 2: bits compared per clock cycle; WIDTH mod DIGIT = 0, and any other value SHALL fail elaboration.
REQ-003 The module SHALL define derived constants STEPS = WIDTH/DIGIT and HW = clog2(WIDTH+1).
REQ-004 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-007 The module SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned.
REQ-008 The module SHALL have port a, input, WIDTH bits: operand A.
REQ-009 The module SHALL have port b, input, WIDTH bits: operand B.
REQ-010 The module SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The module SHALL have port eq, output, 1 bit: A == B.
REQ-013 The module SHALL have port gt, output, 1 bit: A > B.
REQ-014 The module SHALL have port lt, output, 1 bit: A < B.
REQ-015 The module SHALL have port hamming, output, HW bits: popcount(A XOR B).

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with all outputs registered.
REQ-017 In IDLE, on a rising edge with start=1, the block SHALL latch a, b and signed_mode into internal registers, clear its working accumulators, and enter RUN; call that edge E0.
REQ-018 In RUN, at each edge E1..E_STEPS, the block SHALL process one DIGIT-bit chunk of the latched operands, MSB chunk first.
REQ-019 At each RUN chunk the block SHALL add popcount(chunkA XOR chunkB) to the hamming accumulator.
REQ-020 The first chunk with chunkA != chunkB SHALL set the decision: gt if chunkA > chunkB, else lt; later chunks SHALL NOT change a set decision.
REQ-021 When signed_mode is latched as 1, the compare SHALL equal an unsigned compare of both operands with their MSB inverted; hamming SHALL NOT be affected by signed_mode.
REQ-022 There SHALL be no early exit: RUN SHALL last exactly STEPS cycles regardless of the data.
REQ-023 At edge E_STEPS the block SHALL update eq/gt/lt/hamming from the final accumulators, with exactly one of eq, gt, lt high, and enter DONE.
REQ-024 In the DONE cycle done SHALL be 1; the next edge SHALL return the FSM to IDLE with done=0.
REQ-025 Latency SHALL be done high in the cycle following E_STEPS, i.e. STEPS+1 cycles after the start edge.
REQ-026 eq/gt/lt/hamming SHALL hold their last result from DONE until the next DONE, including while busy.
REQ-027 busy SHALL be 1 exactly while in RUN, for STEPS cycles per operation.
REQ-028 start SHALL be ignored in RUN and DONE; no queuing.
REQ-029 Changes on a, b or signed_mode after E0 SHALL NOT affect the operation in flight.

Reset
REQ-030 While rst=1, asynchronously and regardless of clk, the block SHALL force state IDLE and busy=done=eq=gt=lt=0, hamming=0, and clear all internal registers.
REQ-031 On rst asserted mid-RUN or in DONE, the block SHALL abort the operation, produce no done pulse for it, and not retain partial results.
REQ-032 On the first rising edge after rst deasserts, start SHALL be honoured normally.

Verification (WIDTH=8, DIGIT=2, STEPS=4)
REQ-033 Apply rst=1 with no clock running -> all outputs 0 immediately; release, start=0 for 10 cycles -> outputs stay 0, busy=0.
REQ-034 Apply a=0x5A, b=0x5A, unsigned, start pulse -> busy high 4 cycles; done in cycle 5 after start; eq=1, gt=lt=0, hamming=0.
REQ-035 Apply a=0x80, b=0x7F, unsigned -> gt=1, hamming=8; repeat with signed_mode=1 -> lt=1, hamming=8.
REQ-036 Apply a=0x12, b=0x13 with start held high throughout and a changed to 0xFF after E0 -> lt=1, hamming=1; one done per IDLE acceptance; a new compare begins the cycle after DONE.
REQ-037 Start a=0xF0, b=0x0F, then assert rst at edge E2 -> no done pulse, outputs 0; after release, a=0x01, b=0x00 -> gt=1, hamming=1, done at E0+5.
REQ-038 Assert start during DONE -> ignored; the following IDLE cycle's start is accepted, and the prior result stays visible until the new DONE.
